countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Software-programmed down-counter; the write-side complement of the free-running saturating up-counter that software reads.
- An AXI-Lite register block pushes a load value through a valid/ready handshake and issues start/stop strobes. The block counts down, emits a one-cycle expiry pulse, and optionally auto-reloads.
- Also keeps a saturating expiry tally that software can read back.

Parameters:
- WIDTH, 32, width of load value and live count.
- TALLY_WIDTH, 16, width of the saturating expiry tally.

Ports:
- clk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous reset, active-low.
- load_valid  input  1  load_value is valid this cycle.
- load_ready  output  1  block accepts a load this cycle.
- load_value  input  WIDTH  period in cycles; 0 is treated as 1.
- auto_reload  input  1  sampled at each expiry; 1 = restart from the latched period.
- start  input  1  one-cycle strobe: begin counting from the latched period.
- stop  input  1  one-cycle strobe: abort and return to IDLE.
- clear_tally  input  1  synchronously zeroes the tally.
- count  output  WIDTH  live remaining count (registered).
- armed  output  1  state == LOADED.
- busy  output  1  state == RUN.
- expired  output  1  one-cycle registered pulse on each expiry.
- tally  output  TALLY_WIDTH  number of expiries, saturates at all-ones.

Behaviour:
- Reset (areset == 0 at a clock edge): state = IDLE, period_reg = 0, count = 0, expired = 0, tally = 0.
  - load_ready is combinational from state, so it reads 1 after reset.
- States: IDLE, LOADED, RUN.
- load_ready = 1 in IDLE and LOADED, 0 in RUN.
- Load: load_valid && load_ready latches the period and sets count to the same value.
  - period_reg <= (load_value == 0) ? 1 : load_value.
  - count <= (load_value == 0) ? 1 : load_value.
  - The state becomes LOADED.
- Start:
  - In LOADED, start moves to RUN. count is already equal to period_reg.
  - In IDLE and RUN, start is ignored.
- RUN, each edge with no stop:
  - If count > 1: count <= count - 1.
  - Otherwise (count == 1): expired <= 1 for one cycle, and tally increments unless it is all-ones.
    - If auto_reload == 1: count <= period_reg, stay in RUN.
    - Else: count <= 0, go to IDLE.
- Timing: with period N, the first expired pulse is registered N edges after the start edge. With auto_reload, pulses repeat every N cycles. A period of 1 with auto_reload gives expired high every cycle.
- Stop:
  - In LOADED or RUN: go to IDLE, count <= 0, period_reg retained, no expired pulse.
  - In IDLE: no effect.
- Priority, highest first: areset, stop, load, start, decrement/expiry.
  - stop on the same edge as a pending expiry: stop wins; no pulse, tally unchanged.
  - load and start on the same edge in IDLE: load accepted, start ignored; state ends in LOADED.
  - load and start on the same edge in LOADED: new value latched and RUN entered with the new count.
  - load_valid during RUN: not accepted (load_ready = 0). The producer holds load_valid until accepted.
- Tally:
  - clear_tally and an expiry on the same edge: the result is 0.
  - tally saturates and never wraps.
- expired is deasserted on every edge where no expiry occurs.
- Reset mid-RUN: takes effect on that edge with no pulse.

Test Plan:
- areset low 2 cycles, then high -> count = 0, tally = 0, expired = 0, load_ready = 1, armed = 0, busy = 0.
- Load 5 (auto_reload = 0), start next cycle -> count 5,4,3,2,1; expired high exactly 5 edges after the start edge; then count = 0, state IDLE, tally = 1.
- Load 3, auto_reload = 1, start, run 10 cycles -> expired pulses 3 cycles apart (3 pulses); tally = 3.
  - Then drive auto_reload = 0 -> the next expiry returns to IDLE.
- Load 4, start, stop on the edge where count == 1 -> no expired pulse, count = 0, tally unchanged, load_ready = 1.
- Load 0 with auto_reload = 1, start -> expired high every cycle.
  - With TALLY_WIDTH = 4, tally saturates at 15 and holds.
  - Assert clear_tally on a pulse edge -> tally = 0.
- Load 7, then load_valid with value 9 during RUN -> load_ready = 0 and 7 still governs.
  - After expiry the held 9 is accepted and LOADED is re-entered with count = 9.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Software-programmed down-counter. A period is loaded through a
//   valid/ready handshake, start begins counting, and each time the count
//   runs out a one-cycle expired pulse is emitted. The block then either
//   reloads the latched period (auto_reload) or falls back to IDLE. A
//   saturating tally of expiries is kept for software read-back.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   areset       synchronous reset, active-low
//   load_valid   load_value is valid this cycle
//   load_ready   a load is accepted this cycle (IDLE or LOADED)
//   load_value   period in cycles; 0 is treated as 1
//   auto_reload  sampled at each expiry; 1 restarts from the latched period
//   start        strobe: begin counting from the latched period (LOADED only)
//   stop         strobe: abort and return to IDLE
//   clear_tally  zeroes the tally (wins over a same-edge expiry)
//   count        live remaining count
//   armed        state == LOADED
//   busy         state == RUN
//   expired      one-cycle pulse on each expiry
//   tally        expiry count, saturating at all-ones
module countdown_timer #(
    parameter int WIDTH       = 32,
    parameter int TALLY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH-1:0]       load_value,
    input  logic                   auto_reload,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear_tally,
    output logic [WIDTH-1:0]       count,
    output logic                   armed,
    output logic                   busy,
    output logic                   expired,
    output logic [TALLY_WIDTH-1:0] tally
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] period_reg;
    logic [WIDTH-1:0] load_eff;
    logic             stop_hit;
    logic             expire_now;

    assign load_ready = (state != RUN);
    assign armed      = (state == LOADED);
    assign busy       = (state == RUN);

    // A zero period would never expire; treat it as one cycle.
    assign load_eff   = (load_value == '0) ? WIDTH'(1) : load_value;

    // stop only has an effect outside IDLE, and it suppresses any expiry
    // that would otherwise land on the same edge.
    assign stop_hit   = stop && (state != IDLE);
    assign expire_now = (state == RUN) && !stop && (count <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!areset) begin
            state      <= IDLE;
            period_reg <= '0;
            count      <= '0;
            expired    <= 1'b0;
            tally      <= '0;
        end else begin
            expired <= 1'b0;

            if (stop_hit) begin
                state <= IDLE;
                count <= '0;
            end else if (load_valid && load_ready) begin
                period_reg <= load_eff;
                count      <= load_eff;
                // A start that coincides with a load in LOADED runs the new value.
                state      <= (state == LOADED && start) ? RUN : LOADED;
            end else if (state == LOADED && start) begin
                state <= RUN;
            end else if (state == RUN) begin
                if (expire_now) begin
                    expired <= 1'b1;
                    if (auto_reload) begin
                        count <= period_reg;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end

            if (clear_tally)
                tally <= '0;
            else if (expire_now && tally != '1)
                tally <= tally + TALLY_WIDTH'(1);
        end
    end

endmodule
